// File: rtl/memout_page_reader.sv
// memout_page_reader: snoops memout port-A writes, reads back the completed page on a BX change, streams it out.
// Latency: first beat BRAM_LATENCY+1 cycles after the BX-change edge, then one beat per cycle while out_ready holds.
// Backpressure: out_ready low stalls the FIFO head; port-B reads are issued only against free FIFO credit.

// Small synchronous FIFO with a flush; the caller guarantees no push while full.
module memout_page_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_vld,
  input  logic [WIDTH-1:0]           in_dat,
  output logic                       out_vld,
  input  logic                       out_rdy,
  output logic [WIDTH-1:0]           out_dat,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  assign out_vld = (count != '0);
  assign out_dat = mem[rd_ptr];
  assign pop     = out_vld && out_rdy;
  assign push    = in_vld && (count != CW'(DEPTH));

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_dat;
    end
  end

  // Pointers and occupancy; flush empties the FIFO in one cycle.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

module memout_page_reader #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int BRAM_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en_proc,
  input  logic [1:0]            bx_in,
  input  logic                  memout_wea,
  input  logic [ADDR_WIDTH-1:0] memout_writeaddr,
  output logic [ADDR_WIDTH-1:0] memout_readaddr,
  output logic                  memout_enb,
  input  logic [DATA_WIDTH-1:0] memout_dout,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            out_bx,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  done,
  output logic                  overrun
);
  localparam int                    EW      = ADDR_WIDTH - 1;
  localparam logic [ADDR_WIDTH-1:0] CNT_MAX = ADDR_WIDTH'(1 << EW);
  localparam int                    FCW     = $clog2(FIFO_DEPTH+1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [1:0]              bx_q;
  logic                    primed;
  logic                    change;
  logic [ADDR_WIDTH-1:0]   cnt     [2];
  logic [ADDR_WIDTH-1:0]   cnt_inc [2];
  logic [ADDR_WIDTH-1:0]   cnt_nxt [2];
  logic [ADDR_WIDTH-1:0]   start_cnt;
  logic                    rd_page;
  logic [1:0]              rd_bx;
  logic [ADDR_WIDTH-1:0]   rd_cnt;
  logic [ADDR_WIDTH-1:0]   idx;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    load;
  logic                    issue;
  logic                    issue_last;
  logic                    flush;
  logic                    done_nxt;
  logic                    overrun_nxt;
  logic                    last_acc;
  logic                    credit_ok;
  logic [7:0]              credit_used;
  logic [BRAM_LATENCY-1:0] sr_vld;
  logic [BRAM_LATENCY-1:0] sr_last;
  logic                    fifo_vld;
  logic [DATA_WIDTH:0]     fifo_dat;
  logic [FCW-1:0]          fifo_count;
  logic                    unused_entry_bits;

  // Only the page bit of the snooped address matters; counting is per page.
  assign unused_entry_bits = ^memout_writeaddr[EW-1:0];

  assign change     = primed && (bx_in != bx_q);
  assign start_cnt  = cnt_inc[bx_q[0]];
  assign issue_last = (idx == rd_cnt - ADDR_WIDTH'(1));
  assign last_acc   = fifo_vld && out_ready && fifo_dat[DATA_WIDTH];

  // BX tracking: the first cycle after reset only primes bx_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      bx_q   <= '0;
      primed <= 1'b0;
    end else begin
      bx_q   <= bx_in;
      primed <= 1'b1;
    end
  end

  // Per-page entry counts: saturating increment, new write page cleared on a change.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      cnt_inc[p] = cnt[p];
      if (memout_wea && (memout_writeaddr[ADDR_WIDTH-1] == 1'(p)) && (cnt[p] != CNT_MAX)) begin
        cnt_inc[p] = cnt[p] + ADDR_WIDTH'(1);
      end
      cnt_nxt[p] = cnt_inc[p];
      if (change && (bx_in[0] == 1'(p))) begin
        cnt_nxt[p] = (memout_wea && (memout_writeaddr[ADDR_WIDTH-1] == 1'(p))) ?
                     ADDR_WIDTH'(1) : '0;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      cnt[0] <= cnt_nxt[0];
      cnt[1] <= cnt_nxt[1];
    end
  end

  // Reads in flight plus FIFO occupancy must stay within FIFO_DEPTH.
  always_comb begin
    credit_used = 8'(fifo_count);
    for (int i = 0; i < BRAM_LATENCY; i++) begin
      credit_used = credit_used + 8'(sr_vld[i]);
    end
    credit_ok = (credit_used < 8'(FIFO_DEPTH));
  end

  // FSM next state and control; a change in READ/DRAIN aborts and may start the next page at once.
  always_comb begin
    state_nxt   = state;
    load        = 1'b0;
    issue       = 1'b0;
    flush       = 1'b0;
    done_nxt    = 1'b0;
    overrun_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        load = change && en_proc;
      end
      READ: begin
        if (change) begin
          flush       = 1'b1;
          overrun_nxt = 1'b1;
          state_nxt   = IDLE;
          load        = en_proc;
        end else if (credit_ok) begin
          issue = 1'b1;
          if (issue_last) begin
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (last_acc) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
          load      = change && en_proc;
        end else if (change) begin
          flush       = 1'b1;
          overrun_nxt = 1'b1;
          state_nxt   = IDLE;
          load        = en_proc;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (load) begin
      if (start_cnt == '0) begin
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end else begin
        state_nxt = READ;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Readout context: page, BX and length latched at start; idx walks the entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_page <= 1'b0;
      rd_bx   <= '0;
      rd_cnt  <= '0;
      idx     <= '0;
      addr_q  <= '0;
    end else begin
      if (load) begin
        rd_page <= bx_q[0];
        rd_bx   <= bx_q;
        rd_cnt  <= start_cnt;
        idx     <= '0;
      end else if (issue) begin
        idx <= idx + ADDR_WIDTH'(1);
      end
      if (issue) begin
        addr_q <= {rd_page, idx[EW-1:0]};
      end
    end
  end

  // Valid/last shift register matching the BRAM read pipeline.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      sr_vld  <= '0;
      sr_last <= '0;
    end else begin
      sr_vld[0]  <= issue;
      sr_last[0] <= issue_last;
      for (int i = 1; i < BRAM_LATENCY; i++) begin
        sr_vld[i]  <= sr_vld[i-1];
        sr_last[i] <= sr_last[i-1];
      end
    end
  end

  // Single-cycle status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      done    <= done_nxt;
      overrun <= overrun_nxt;
    end
  end

  memout_page_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .in_vld  (sr_vld[BRAM_LATENCY-1]),
    .in_dat  ({sr_last[BRAM_LATENCY-1], memout_dout}),
    .out_vld (fifo_vld),
    .out_rdy (out_ready),
    .out_dat (fifo_dat),
    .count   (fifo_count)
  );

  assign memout_enb      = issue;
  assign memout_readaddr = issue ? {rd_page, idx[EW-1:0]} : addr_q;
  assign out_valid       = fifo_vld;
  assign out_data        = fifo_vld ? fifo_dat[DATA_WIDTH-1:0] : '0;
  assign out_last        = fifo_vld && fifo_dat[DATA_WIDTH];
  assign out_bx          = rd_bx;
endmodule

// File: tb/tb_memout_page_reader.sv
// Bench for memout_page_reader: BRAM model, directed stimulus, queue-based scoreboard.
// Stimulus pushes expected beats; a negedge monitor pops and compares each accepted beat.
// Also checks latency, stall stability, done/overrun pulses and reset behaviour.
module tb_memout_page_reader;
  localparam int DW = 32;
  localparam int AW = 5;

  typedef struct packed {
    logic [31:0] dat;
    logic [1:0]  bx;
    logic        last;
    logic        first;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          en_proc;
  logic [1:0]    bx_in;
  logic          wea;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [AW-1:0] readaddr;
  logic          enb;
  logic [DW-1:0] dout = '0;
  logic [DW-1:0] out_data;
  logic [1:0]    out_bx;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          done;
  logic          overrun;

  logic [DW-1:0] mem [32];
  logic [DW-1:0] pipe1 = '0;

  beat_t exp_q[$];
  beat_t mon_e;
  int n_cmp = 0;
  int n_err = 0;
  int done_seen = 0;
  int ovr_seen = 0;
  int exp_done = 0;
  int exp_ovr = 0;
  int cyc = 0;
  int t_first = 0;
  int last_span = -1;
  int lat;
  int act;
  logic          prev_stall = 1'b0;
  logic          prev_last_hs = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last_b = 1'b0;

  memout_page_reader #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .BRAM_LATENCY (2),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .en_proc          (en_proc),
    .bx_in            (bx_in),
    .memout_wea       (wea),
    .memout_writeaddr (waddr),
    .memout_readaddr  (readaddr),
    .memout_enb       (enb),
    .memout_dout      (dout),
    .out_data         (out_data),
    .out_bx           (out_bx),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_last         (out_last),
    .done             (done),
    .overrun          (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Dual-port BRAM: port A write, port B read with two-cycle latency.
  always @(posedge clk) begin
    if (wea) mem[waddr] <= wdata;
    if (enb) pipe1 <= mem[readaddr];
    dout <= pipe1;
  end

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] required);
    n_cmp++;
    if (actual !== required) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, actual, required, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wea = 1'b1;
    waddr = a;
    wdata = d;
    tick();
    wea = 1'b0;
  endtask

  task automatic push_page(input logic [31:0] base, input int n, input logic [1:0] bx);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.dat = base + 32'(i);
      b.bx = bx;
      b.last = (i == n - 1);
      b.first = (i == 0);
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_drain(input int max_cyc, input bit toggle);
    for (int i = 0; i < max_cyc; i++) begin
      if (exp_q.size() == 0) break;
      if (toggle) out_ready = ~out_ready;
      tick();
    end
    check("drain_complete", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
    out_ready = 1'b1;
    repeat (3) tick();
  endtask

  // Monitor: scoreboard pop on every handshake, stall stability, done after last.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
      prev_last_hs = 1'b0;
    end else begin
      if (prev_stall && !overrun) begin
        check("stall_hold_valid", 64'(out_valid), 64'(1));
        check("stall_hold_data", 64'({out_last, out_data}), 64'({prev_last_b, prev_data}));
      end
      if (prev_last_hs) check("done_after_last", 64'(done), 64'(1));
      if (done) done_seen++;
      if (overrun) ovr_seen++;
      prev_last_hs = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_beat: actual data=0x%0h bx=%0d last=%0b, required no beat", out_data, out_bx, out_last);
        end else begin
          mon_e = exp_q.pop_front();
          check("beat_data", 64'(out_data), 64'(mon_e.dat));
          check("beat_bx", 64'(out_bx), 64'(mon_e.bx));
          check("beat_last", 64'(out_last), 64'(mon_e.last));
          if (mon_e.first) t_first = cyc;
          if (mon_e.last) last_span = cyc - t_first;
        end
        prev_last_hs = out_last;
      end
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
      prev_last_b = out_last;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; en_proc = 1'b1; bx_in = 2'd0; wea = 1'b0; waddr = '0; wdata = '0; out_ready = 1'b1;
    repeat (3) tick();
    check("reset_outputs", 64'({out_valid, out_last, done, overrun, enb, readaddr, out_bx, out_data}), 64'(0));
    reset = 1'b0;
    tick();

    // Basic readout: 5 entries on page 0, BX 0 -> 1.
    for (int i = 0; i < 5; i++) write_word(AW'(i), 32'h10 + 32'(i));
    push_page(32'h10, 5, 2'd0); exp_done++;
    bx_in = 2'd1; tick();
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (out_valid && lat == 0) lat = c;
    end
    check("basic_first_valid_latency", 64'(lat), 64'(3));
    wait_drain(40, 1'b0);

    // Ping-pong: 16 entries on page 1 plus rewrites (count saturates), BX 1 -> 2.
    for (int i = 0; i < 16; i++) write_word(AW'(16 + i), 32'h100 + 32'(i));
    write_word(AW'(31), 32'h10F);
    write_word(AW'(31), 32'h10F);
    push_page(32'h100, 16, 2'd1); exp_done++;
    bx_in = 2'd2; tick();
    for (int i = 0; i < 3; i++) write_word(AW'(i), 32'h200 + 32'(i));
    wait_drain(60, 1'b0);
    check("pingpong_span_no_bubbles", 64'(last_span), 64'(15));

    // Write to the old page in the change cycle is still counted.
    push_page(32'h200, 4, 2'd2); exp_done++;
    bx_in = 2'd3; wea = 1'b1; waddr = AW'(3); wdata = 32'h203; tick(); wea = 1'b0;
    wait_drain(40, 1'b0);

    // Backpressure: 8 entries, out_ready toggling; new-page write in the change cycle.
    for (int i = 0; i < 8; i++) write_word(AW'(16 + i), 32'h400 + 32'(i));
    push_page(32'h400, 8, 2'd3); exp_done++;
    bx_in = 2'd0; wea = 1'b1; waddr = AW'(0); wdata = 32'h500; tick(); wea = 1'b0;
    wait_drain(80, 1'b1);

    // That new-page write left a single entry.
    push_page(32'h500, 1, 2'd0); exp_done++;
    bx_in = 2'd1; tick();
    wait_drain(40, 1'b0);

    // Empty page.
    bx_in = 2'd2; tick();
    exp_done++;
    check("empty_done", 64'(done), 64'(1));
    check("empty_no_valid", 64'(out_valid), 64'(0));
    tick();
    check("empty_done_single", 64'(done), 64'(0));
    repeat (4) tick();

    // en_proc low: change ignored.
    write_word(AW'(0), 32'h600);
    write_word(AW'(1), 32'h601);
    en_proc = 1'b0; bx_in = 2'd3;
    act = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (enb || out_valid || done || overrun) act++;
    end
    check("enproc0_no_activity", 64'(act), 64'(0));
    en_proc = 1'b1;

    // Overrun: full page stalled, second change 6 cycles later.
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) write_word(AW'(16 + i), 32'h700 + 32'(i));
    push_page(32'h700, 16, 2'd3);
    bx_in = 2'd0; tick();
    write_word(AW'(0), 32'h800);
    write_word(AW'(1), 32'h801);
    repeat (3) tick();
    bx_in = 2'd1; tick();
    check("overrun_pulse", 64'(overrun), 64'(1));
    check("overrun_no_done", 64'(done), 64'(0));
    exp_q.delete();
    push_page(32'h800, 2, 2'd0); exp_done++; exp_ovr++;
    out_ready = 1'b1;
    wait_drain(40, 1'b0);

    // Reset during READ, priming ignores the first change, next change reads.
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) write_word(AW'(16 + i), 32'h900 + 32'(i));
    bx_in = 2'd2; tick();
    tick(); tick();
    reset = 1'b1; tick();
    check("reset_mid_outputs", 64'({out_valid, out_last, done, overrun, enb, readaddr, out_bx, out_data}), 64'(0));
    reset = 1'b0; bx_in = 2'd3; out_ready = 1'b1;
    act = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (enb || out_valid || done || overrun) act++;
    end
    check("priming_ignores_change", 64'(act), 64'(0));
    for (int i = 0; i < 3; i++) write_word(AW'(16 + i), 32'hA00 + 32'(i));
    push_page(32'hA00, 3, 2'd3); exp_done++;
    bx_in = 2'd0; tick();
    wait_drain(40, 1'b0);

    check("done_count", 64'(done_seen), 64'(exp_done));
    check("overrun_count", 64'(ovr_seen), 64'(exp_ovr));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
